// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM device-side responder: command encodings,
// mode register field positions and sticky error flag indices.
package sdram_pkg;

    typedef enum logic [2:0] {
        CMD_LOAD_MODE  = 3'b000,
        CMD_REFRESH    = 3'b001,
        CMD_PRECHARGE  = 3'b010,
        CMD_ACTIVE     = 3'b011,
        CMD_WRITE      = 3'b100,
        CMD_READ       = 3'b101,
        CMD_BURST_TERM = 3'b110,
        CMD_NOP        = 3'b111
    } cmd_t;

    localparam int MODE_CL_LSB = 4;
    localparam int MODE_CL_MSB = 6;
    localparam int MODE_BL_LSB = 0;
    localparam int MODE_BL_MSB = 2;
    localparam int MODE_WB     = 9;

    localparam int ERR_NOINIT   = 0;
    localparam int ERR_ACT_OPEN = 1;
    localparam int ERR_CLOSED   = 2;
    localparam int ERR_TRCD     = 3;
    localparam int ERR_BUSY     = 4;
    localparam int ERR_MODE     = 5;
    localparam int ERR_COLLIDE  = 6;
    localparam int ERR_AP_INFO  = 7;

    // Only CAS latency 2 or 3 with single-word bursts is supported.
    function automatic logic mode_fields_ok(input logic [2:0] cl, input logic [2:0] bl);
        return ((cl == 3'd2) || (cl == 3'd3)) && (bl == 3'd0);
    endfunction

endpackage

// File: rtl/sdram_bank_tracker.sv
// Per-bank state: open flag, latched row and a saturating age counter used
// to check the ACTIVE-to-access delay.
module sdram_bank_tracker #(
    parameter int MEM_ROW_BITS = 4,
    parameter int TRCD         = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    activate,
    input  logic                    close,
    input  logic [MEM_ROW_BITS-1:0] row_in,
    output logic                    is_open,
    output logic [MEM_ROW_BITS-1:0] row,
    output logic                    trcd_met
);

    localparam int AGE_W = (TRCD < 1) ? 1 : $clog2(TRCD + 1);

    logic [AGE_W-1:0] age;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_open <= 1'b0;
            row     <= '0;
            age     <= '0;
        end else if (activate) begin
            is_open <= 1'b1;
            row     <= row_in;
            age     <= '0;
        end else if (close) begin
            is_open <= 1'b0;
        end else if (is_open && (int'(age) < TRCD)) begin
            age <= age + 1'b1;
        end
    end

    // age holds edges since ACTIVE minus one, so the current edge completes it.
    assign trcd_met = (int'(age) + 1) >= TRCD;

endmodule

// File: rtl/sdram_responder.sv
// Device-side model of a 32-bit SDR SDRAM: decodes commands, stores data in a
// reduced array, returns reads after CAS latency and flags protocol errors.
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int COL_BITS     = 8,
    parameter int MEM_ROW_BITS = 4,
    parameter int TRCD         = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sd_cke,
    input  logic        sd_cs,
    input  logic        sd_ras,
    input  logic        sd_cas,
    input  logic        sd_we,
    input  logic [1:0]  sd_ba,
    input  logic [10:0] sd_addr,
    input  logic [3:0]  sd_dqm,
    input  logic [31:0] sd_din,
    output logic [31:0] sd_dout,
    output logic        sd_doe,
    output logic        mode_valid,
    output logic [15:0] refresh_count,
    output logic [7:0]  error
);

    localparam int ADDR_W = 2 + MEM_ROW_BITS + COL_BITS;
    localparam int DEPTH  = 1 << ADDR_W;

    cmd_t                    cmd;
    logic                    is_act, is_rd, is_wr, is_pre, is_ref, is_lmr;
    logic [3:0]              bank_open, bank_trcd, bank_close;
    logic [MEM_ROW_BITS-1:0] bank_row [4];
    logic                    tgt_open, any_open, other_open, do_access;
    logic [ADDR_W-1:0]       mem_addr;
    logic [7:0]              err_set;
    logic                    cl_is3;
    logic [31:0]             mem [DEPTH];
    logic [2:0]              pipe_vld;
    logic [31:0]             pipe_data [3];
    logic                    unused_addr;

    assign cmd    = (sd_cke && !sd_cs) ? cmd_t'({sd_ras, sd_cas, sd_we}) : CMD_NOP;
    assign is_act = (cmd == CMD_ACTIVE);
    assign is_rd  = (cmd == CMD_READ);
    assign is_wr  = (cmd == CMD_WRITE);
    assign is_pre = (cmd == CMD_PRECHARGE);
    assign is_ref = (cmd == CMD_REFRESH);
    assign is_lmr = (cmd == CMD_LOAD_MODE);

    assign tgt_open   = bank_open[sd_ba];
    assign any_open   = |bank_open;
    assign other_open = |(bank_open & ~(4'b0001 << sd_ba));
    assign do_access  = (is_rd || is_wr) && tgt_open;
    assign mem_addr   = {sd_ba, bank_row[sd_ba], sd_addr[COL_BITS-1:0]};
    assign unused_addr = ^{sd_addr[MODE_WB], sd_addr};

    for (genvar b = 0; b < 4; b++) begin : g_bank
        sdram_bank_tracker #(
            .MEM_ROW_BITS(MEM_ROW_BITS),
            .TRCD        (TRCD)
        ) u_bank (
            .clk     (clk),
            .reset_n (reset_n),
            .activate(is_act && (sd_ba == 2'(b))),
            .close   (bank_close[b]),
            .row_in  (sd_addr[MEM_ROW_BITS-1:0]),
            .is_open (bank_open[b]),
            .row     (bank_row[b]),
            .trcd_met(bank_trcd[b])
        );
    end

    // Explicit precharge or auto-precharge at the end of an executed access.
    always_comb begin
        bank_close = '0;
        for (int b = 0; b < 4; b++) begin
            if (is_pre && (sd_addr[10] || (sd_ba == 2'(b))))
                bank_close[b] = 1'b1;
            if (do_access && sd_addr[10] && (sd_ba == 2'(b)))
                bank_close[b] = 1'b1;
        end
    end

    always_comb begin
        err_set = '0;
        if ((is_act || is_rd || is_wr) && !mode_valid) err_set[ERR_NOINIT] = 1'b1;
        if (is_act && tgt_open)                          err_set[ERR_ACT_OPEN] = 1'b1;
        if ((is_rd || is_wr) && !tgt_open)               err_set[ERR_CLOSED] = 1'b1;
        if (do_access && !bank_trcd[sd_ba])              err_set[ERR_TRCD] = 1'b1;
        if ((is_ref || is_lmr) && any_open)              err_set[ERR_BUSY] = 1'b1;
        if (is_lmr && !any_open &&
            !mode_fields_ok(sd_addr[MODE_CL_MSB:MODE_CL_LSB], sd_addr[MODE_BL_MSB:MODE_BL_LSB]))
            err_set[ERR_MODE] = 1'b1;
        if (is_wr && sd_doe)                             err_set[ERR_COLLIDE] = 1'b1;
        if ((is_rd || is_wr) && sd_addr[10] && other_open)
            err_set[ERR_AP_INFO] = 1'b1;
    end

    // Storage is deliberately left unreset; its contents are undefined after reset.
    always_ff @(posedge clk) begin
        if (is_wr && tgt_open) begin
            for (int i = 0; i < 4; i++) begin
                if (!sd_dqm[i])
                    mem[mem_addr][8*i +: 8] <= sd_din[8*i +: 8];
            end
        end
    end

    // Reads enter the pipe at a depth chosen by the CL in force when issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cl_is3        <= 1'b0;
            mode_valid    <= 1'b0;
            refresh_count <= '0;
            error         <= '0;
            pipe_vld      <= '0;
            pipe_data[0]  <= '0;
            pipe_data[1]  <= '0;
            pipe_data[2]  <= '0;
            sd_doe        <= 1'b0;
            sd_dout       <= '0;
        end else begin
            error <= error | err_set;
            if (is_ref)
                refresh_count <= refresh_count + 16'd1;
            if (is_lmr && !any_open &&
                mode_fields_ok(sd_addr[MODE_CL_MSB:MODE_CL_LSB], sd_addr[MODE_BL_MSB:MODE_BL_LSB])) begin
                cl_is3     <= (sd_addr[MODE_CL_MSB:MODE_CL_LSB] == 3'd3);
                mode_valid <= 1'b1;
            end

            pipe_vld[0]  <= 1'b0;
            pipe_data[0] <= '0;
            pipe_vld[1]  <= pipe_vld[0];
            pipe_data[1] <= pipe_data[0];
            pipe_vld[2]  <= pipe_vld[1];
            pipe_data[2] <= pipe_data[1];
            sd_doe       <= pipe_vld[2];
            sd_dout      <= pipe_vld[2] ? pipe_data[2] : '0;

            if (is_rd && tgt_open) begin
                if (cl_is3) begin
                    pipe_vld[0]  <= 1'b1;
                    pipe_data[0] <= mem[mem_addr];
                end else begin
                    pipe_vld[1]  <= 1'b1;
                    pipe_data[1] <= mem[mem_addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_responder.sv
// Self-checking bench for sdram_responder: directed protocol checks followed
// by randomized command streams compared against an edge-indexed model.
module tb_sdram_responder;

    localparam int TRCD = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sd_cke = 1'b1, sd_cs = 1'b1, sd_ras = 1'b1, sd_cas = 1'b1, sd_we = 1'b1;
    logic [1:0]  sd_ba = '0;
    logic [10:0] sd_addr = '0;
    logic [3:0]  sd_dqm = '0;
    logic [31:0] sd_din = '0;
    logic [31:0] sd_dout;
    logic        sd_doe, mode_valid;
    logic [15:0] refresh_count;
    logic [7:0]  error;

    always #5 clk = ~clk;

    sdram_responder #(.COL_BITS(8), .MEM_ROW_BITS(4), .TRCD(TRCD)) dut (
        .clk(clk), .reset_n(reset_n), .sd_cke(sd_cke), .sd_cs(sd_cs),
        .sd_ras(sd_ras), .sd_cas(sd_cas), .sd_we(sd_we), .sd_ba(sd_ba),
        .sd_addr(sd_addr), .sd_dqm(sd_dqm), .sd_din(sd_din), .sd_dout(sd_dout),
        .sd_doe(sd_doe), .mode_valid(mode_valid), .refresh_count(refresh_count),
        .error(error)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model state: banks, mode, counters, known memory words, and reads keyed
    // by the clock edge number on which their data must appear.
    bit          mOpen [4];
    int          mRow [4];
    int          mActEdge [4];
    bit          mModeValid;
    int          mCl;
    int          mRefresh;
    logic [7:0]  mErr;
    logic [31:0] mMem [int];
    logic [31:0] rdData [int];
    bit          rdKnown [int];
    int          edgeNum = 0;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at edge %0d: got 0x%08h, expected 0x%08h", name, edgeNum, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int b = 0; b < 4; b++) begin
            mOpen[b] = 0;
            mRow[b] = 0;
            mActEdge[b] = 0;
        end
        mModeValid = 0;
        mCl = 2;
        mRefresh = 0;
        mErr = '0;
        mMem.delete();
        rdData.delete();
        rdKnown.delete();
    endtask

    // Predict the effect of the edge about to happen from the driven inputs.
    task automatic modelStep();
        logic [2:0] c;
        bit curDoe, isAcc, anyOpen, otherOpen;
        int a, b;
        logic [31:0] merged;
        edgeNum++;
        curDoe = rdKnown.exists(edgeNum - 1);
        b = int'(sd_ba);
        anyOpen = mOpen[0] | mOpen[1] | mOpen[2] | mOpen[3];
        otherOpen = 0;
        for (int i = 0; i < 4; i++) if (i != b && mOpen[i]) otherOpen = 1;
        c = (sd_cke && !sd_cs) ? {sd_ras, sd_cas, sd_we} : 3'b111;
        isAcc = (c == 3'b101) || (c == 3'b100);
        if ((c == 3'b011 || isAcc) && !mModeValid) mErr[0] = 1;
        if (c == 3'b011) begin
            if (mOpen[b]) mErr[1] = 1;
            mOpen[b] = 1;
            mRow[b] = int'(sd_addr[3:0]);
            mActEdge[b] = edgeNum;
        end else if (isAcc) begin
            if (sd_addr[10] && otherOpen) mErr[7] = 1;
            if (c == 3'b100 && curDoe) mErr[6] = 1;
            if (!mOpen[b]) begin
                mErr[2] = 1;
            end else begin
                if (edgeNum - mActEdge[b] < TRCD) mErr[3] = 1;
                a = b * 4096 + mRow[b] * 256 + int'(sd_addr[7:0]);
                if (c == 3'b100) begin
                    if (mMem.exists(a) || sd_dqm == 4'b0000) begin
                        merged = mMem.exists(a) ? mMem[a] : 32'h0;
                        for (int i = 0; i < 4; i++)
                            if (!sd_dqm[i]) merged[8*i +: 8] = sd_din[8*i +: 8];
                        mMem[a] = merged;
                    end
                end else begin
                    rdKnown[edgeNum + mCl] = mMem.exists(a);
                    rdData[edgeNum + mCl] = mMem.exists(a) ? mMem[a] : 32'h0;
                end
                if (sd_addr[10]) mOpen[b] = 0;
            end
        end else if (c == 3'b010) begin
            for (int i = 0; i < 4; i++) if (sd_addr[10] || i == b) mOpen[i] = 0;
        end else if (c == 3'b001) begin
            if (anyOpen) mErr[4] = 1;
            mRefresh++;
        end else if (c == 3'b000) begin
            if (anyOpen) mErr[4] = 1;
            else if ((sd_addr[6:4] == 3'd2 || sd_addr[6:4] == 3'd3) && sd_addr[2:0] == 3'd0) begin
                mCl = int'(sd_addr[6:4]);
                mModeValid = 1;
            end else mErr[5] = 1;
        end
    endtask

    task automatic checkOutput();
        bit eDoe;
        eDoe = rdKnown.exists(edgeNum);
        checkVal("sd_doe", {31'b0, sd_doe}, {31'b0, eDoe});
        if (eDoe && rdKnown[edgeNum]) checkVal("sd_dout", sd_dout, rdData[edgeNum]);
        checkVal("error", {24'b0, error}, {24'b0, mErr});
        checkVal("mode_valid", {31'b0, mode_valid}, {31'b0, mModeValid});
        checkVal("refresh_count", {16'b0, refresh_count}, {16'b0, mRefresh[15:0]});
    endtask

    task automatic applyStimulus(input logic [2:0] c, input logic [1:0] ba, input logic [10:0] addr,
                                 input logic [3:0] dqm, input logic [31:0] din,
                                 input logic cke = 1'b1, input logic cs = 1'b0);
        sd_cke = cke;
        sd_cs = cs;
        {sd_ras, sd_cas, sd_we} = c;
        sd_ba = ba;
        sd_addr = addr;
        sd_dqm = dqm;
        sd_din = din;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic nop();
        applyStimulus(3'b111, 2'd0, 11'd0, 4'd0, 32'd0);
    endtask

    task automatic resetPulse();
        reset_n = 1'b0;
        #1;
        modelReset();
        checkVal("async_doe", {31'b0, sd_doe}, 32'd0);
        @(posedge clk);
        #1;
        edgeNum++;
        checkOutput();
        checkVal("reset_dout", sd_dout, 32'd0);
        reset_n = 1'b1;
    endtask

    task automatic initMode(input logic [10:0] modeWord);
        applyStimulus(3'b010, 2'd0, 11'h400, 4'd0, 32'd0);
        applyStimulus(3'b000, 2'd0, modeWord, 4'd0, 32'd0);
    endtask

    initial begin
        logic [2:0] c;
        logic [10:0] addr;
        int r;

        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        checkVal("rst_doe", {31'b0, sd_doe}, 32'd0);
        checkVal("rst_dout", sd_dout, 32'd0);
        checkVal("rst_mode_valid", {31'b0, mode_valid}, 32'd0);
        checkVal("rst_refresh", {16'b0, refresh_count}, 32'd0);
        checkVal("rst_error", {24'b0, error}, 32'd0);
        reset_n = 1'b1;

        initMode(11'h220);
        checkVal("init_mode_valid", {31'b0, mode_valid}, 32'd1);
        checkVal("init_error", {24'b0, error}, 32'd0);

        applyStimulus(3'b011, 2'd1, 11'd3, 4'd0, 32'd0);
        nop();
        nop();
        applyStimulus(3'b100, 2'd1, 11'h012, 4'b0000, 32'hDEADBEEF);
        applyStimulus(3'b010, 2'd1, 11'h000, 4'd0, 32'd0);
        applyStimulus(3'b011, 2'd1, 11'd3, 4'd0, 32'd0);
        nop();
        applyStimulus(3'b101, 2'd1, 11'h012, 4'b1111, 32'd0);
        nop();
        checkVal("cl2_doe_edge1", {31'b0, sd_doe}, 32'd0);
        nop();
        checkVal("cl2_doe_edge2", {31'b0, sd_doe}, 32'd1);
        checkVal("cl2_dout", sd_dout, 32'hDEADBEEF);
        nop();
        checkVal("cl2_doe_edge3", {31'b0, sd_doe}, 32'd0);

        applyStimulus(3'b100, 2'd1, 11'h012, 4'b0101, 32'h11223344);
        applyStimulus(3'b101, 2'd1, 11'h012, 4'd0, 32'd0);
        nop();
        nop();
        checkVal("dqm_merge", sd_dout, 32'h11AD33EF);
        checkVal("clean_error", {24'b0, error}, 32'd0);

        applyStimulus(3'b010, 2'd0, 11'h400, 4'd0, 32'd0);
        applyStimulus(3'b000, 2'd0, 11'h230, 4'd0, 32'd0);
        applyStimulus(3'b011, 2'd1, 11'd3, 4'd0, 32'd0);
        nop();
        applyStimulus(3'b101, 2'd1, 11'h012, 4'd0, 32'd0);
        nop();
        nop();
        checkVal("cl3_doe_edge2", {31'b0, sd_doe}, 32'd0);
        nop();
        checkVal("cl3_doe_edge3", {31'b0, sd_doe}, 32'd1);
        checkVal("cl3_dout", sd_dout, 32'h11AD33EF);

        applyStimulus(3'b101, 2'd1, 11'h412, 4'd0, 32'd0);
        applyStimulus(3'b101, 2'd1, 11'h012, 4'd0, 32'd0);
        nop();
        nop();
        nop();
        checkVal("closed_read_no_doe", {31'b0, sd_doe}, 32'd0);
        checkVal("closed_read_err2", {31'b0, error[2]}, 32'd1);

        applyStimulus(3'b011, 2'd2, 11'd5, 4'd0, 32'd0);
        applyStimulus(3'b101, 2'd2, 11'h001, 4'd0, 32'd0);
        checkVal("trcd_err3", {31'b0, error[3]}, 32'd1);
        applyStimulus(3'b001, 2'd0, 11'd0, 4'd0, 32'd0);
        checkVal("refresh_busy_err4", {31'b0, error[4]}, 32'd1);
        checkVal("refresh_count_one", {16'b0, refresh_count}, 32'd1);

        applyStimulus(3'b101, 2'd2, 11'h001, 4'd0, 32'd0);
        nop();
        nop();
        nop();
        checkVal("pre_reset_doe", {31'b0, sd_doe}, 32'd1);
        reset_n = 1'b0;
        #1;
        checkVal("midread_doe", {31'b0, sd_doe}, 32'd0);
        checkVal("midread_error", {24'b0, error}, 32'd0);
        checkVal("midread_refresh", {16'b0, refresh_count}, 32'd0);
        checkVal("midread_mode_valid", {31'b0, mode_valid}, 32'd0);
        checkVal("midread_dout", sd_dout, 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        edgeNum++;
        reset_n = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) begin
                if (n != 0) resetPulse();
                initMode(($urandom_range(0, 1) != 0) ? 11'h230 : 11'h220);
            end
            r = $urandom_range(0, 99);
            addr = 11'($urandom);
            addr[10] = ($urandom_range(0, 3) == 0);
            if (r < 22) begin
                c = 3'b011;
                addr[3:0] = 4'($urandom_range(0, 3));
            end else if (r < 50) begin
                c = 3'b101;
                addr[7:0] = 8'($urandom_range(0, 7));
            end else if (r < 72) begin
                c = 3'b100;
                addr[7:0] = 8'($urandom_range(0, 7));
            end else if (r < 82) c = 3'b010;
            else if (r < 85) c = 3'b001;
            else if (r < 88) begin
                c = 3'b000;
                addr[6:4] = 3'($urandom_range(1, 4));
                addr[2:0] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            end else if (r < 90) c = 3'b110;
            else c = 3'b111;
            applyStimulus(c, 2'($urandom_range(0, 3)), addr, 4'($urandom), $urandom,
                          ($urandom_range(0, 19) != 0), ($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
